// File: rtl/inst_buffer_mp.sv
// Multi-port instruction buffer between predecode and decode: circular FIFO of {inst, fsq_idx}.
// Latency: enqueued entries become visible on the outputs one cycle later; no bypass.
// Backpressure: in_ready only when a full IN_WIDTH packet fits; an enqueue without it is dropped.
module inst_buffer_mp #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int INST_W    = 32,
  parameter int FSQ_W     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_WIDTH-1:0]              in_en,
  input  logic [IN_WIDTH*INST_W-1:0]       in_inst,
  input  logic [FSQ_W-1:0]                 in_fsq_idx,
  output logic                             in_ready,
  output logic [OUT_WIDTH-1:0]             out_valid,
  output logic [OUT_WIDTH*INST_W-1:0]      out_inst,
  output logic [OUT_WIDTH*FSQ_W-1:0]       out_fsq_idx,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]   deq_num,
  input  logic                             flush,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int DQ_W  = $clog2(OUT_WIDTH+1);
  localparam int NIN_W = $clog2(IN_WIDTH+1);

  logic [INST_W-1:0] mem_inst_q [DEPTH];
  logic [FSQ_W-1:0]  mem_fsq_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NIN_W-1:0]    n_in;
  logic [DQ_W-1:0]     n_out;
  logic                enq_fire;
  logic [IN_WIDTH-1:0] in_en_p1;
  int                  deq_lim;

  // Space check uses only the registered occupancy, so in_ready has no input path.
  always_comb begin
    in_ready  = (DEPTH - int'(count_q)) >= IN_WIDTH;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_valid[i] = int'(count_q) > i;
    end
  end

  // Lane count of the incoming packet (lanes are a contiguous prefix).
  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      n_in = n_in + NIN_W'(in_en[i]);
    end
  end

  // Clamp the dequeue request to the number of valid output lanes.
  always_comb begin
    deq_lim = (int'(count_q) < OUT_WIDTH) ? int'(count_q) : OUT_WIDTH;
    n_out   = (int'(deq_num) < deq_lim) ? deq_num : DQ_W'(deq_lim);
  end

  // Pointer/occupancy update; flush discards both enqueue and dequeue of this cycle.
  always_comb begin
    enq_fire = in_ready && (|in_en) && !flush;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(n_out);
      count_d = count_q - CNT_W'(n_out);
      if (enq_fire) begin
        tail_d  = tail_q + PTR_W'(n_in);
        count_d = count_d + CNT_W'(n_in);
      end
    end
  end

  // Control registers clear asynchronously so outputs drop as soon as reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write: lane i lands at tail+i, wrapping naturally via pointer width.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (enq_fire && (i < int'(n_in))) begin
        mem_inst_q[tail_q + PTR_W'(i)] <= in_inst[i*INST_W +: INST_W];
        mem_fsq_q[tail_q + PTR_W'(i)]  <= in_fsq_idx;
      end
    end
  end

  // Output lanes read the oldest entries starting at head.
  always_comb begin
    out_inst    = '0;
    out_fsq_idx = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_inst[i*INST_W +: INST_W] = mem_inst_q[head_q + PTR_W'(i)];
      out_fsq_idx[i*FSQ_W +: FSQ_W] = mem_fsq_q[head_q + PTR_W'(i)];
    end
  end

  assign count    = count_q;
  assign in_en_p1 = in_en + IN_WIDTH'(1);

  // Valid lanes must form a prefix starting at lane 0.
  a_in_en_contig: assert property (@(posedge clk) disable iff (!rst)
    (in_en & in_en_p1) == '0);

  // Decode may not consume more lanes than are presented.
  a_deq_legal: assert property (@(posedge clk) disable iff (!rst || flush)
    int'(deq_num) <= deq_lim);

endmodule

// File: tb/tb_inst_buffer_mp.sv
module tb_inst_buffer_mp;

  localparam int IW = 4;
  localparam int OW = 4;
  localparam int DP = 16;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  fsq;
  } ent_t;

  logic         clk;
  logic         rst;
  logic [3:0]   in_en;
  logic [127:0] in_inst;
  logic [3:0]   in_fsq_idx;
  logic         in_ready;
  logic [3:0]   out_valid;
  logic [127:0] out_inst;
  logic [15:0]  out_fsq_idx;
  logic [2:0]   deq_num;
  logic         flush;
  logic [4:0]   count;

  inst_buffer_mp dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_inst(in_inst), .in_fsq_idx(in_fsq_idx),
    .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
    .out_fsq_idx(out_fsq_idx), .deq_num(deq_num), .flush(flush), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  ent_t q[$];
  int   cur_nin;
  int   cur_deq;
  bit   cur_fl;
  logic [31:0] saved;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present inputs for the next edge; instruction words are random.
  task automatic drive(input int nin, input logic [3:0] fsq, input int dq, input bit fl);
    cur_nin = nin;
    cur_deq = dq;
    cur_fl  = fl;
    in_en   = 4'((1 << nin) - 1);
    for (int i = 0; i < IW; i++) in_inst[i*32 +: 32] = $urandom;
    in_fsq_idx = fsq;
    deq_num    = 3'(dq);
    flush      = fl;
  endtask

  // Reference model: a plain queue of entries, updated from the rules on each edge.
  task automatic model_step();
    int sz;
    int no;
    bit rdy;
    if (cur_fl) begin
      q.delete();
    end else begin
      sz  = q.size();
      rdy = (DP - sz) >= IW;
      no  = (cur_deq < sz) ? cur_deq : sz;
      if (no > OW) no = OW;
      repeat (no) void'(q.pop_front());
      if (rdy) begin
        for (int i = 0; i < cur_nin; i++) begin
          ent_t e;
          e.inst = in_inst[i*32 +: 32];
          e.fsq  = in_fsq_idx;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] ev;
    for (int i = 0; i < OW; i++) ev[i] = q.size() > i;
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'((DP - q.size()) >= IW));
    check("out_valid", 64'(out_valid), 64'(ev));
    for (int i = 0; i < OW; i++) begin
      if (i < q.size()) begin
        check($sformatf("inst%0d", i), 64'(out_inst[i*32 +: 32]), 64'(q[i].inst));
        check($sformatf("fsq%0d", i), 64'(out_fsq_idx[i*4 +: 4]), 64'(q[i].fsq));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 4'd0, 0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b1;
    cyc();
    check("idle_count", 64'(count), 64'd0);

    // Three-lane packet, then partial dequeue of two.
    drive(3, 4'd3, 0, 1'b0);
    saved = in_inst[64 +: 32];
    cyc();
    check("t2_valid", 64'(out_valid), 64'h7);
    check("t2_fsq2", 64'(out_fsq_idx[8 +: 4]), 64'd3);
    drive(0, 4'd0, 2, 1'b0);
    cyc();
    check("t2_valid_after", 64'(out_valid), 64'h1);
    check("t2_lane0_C", 64'(out_inst[0 +: 32]), 64'(saved));

    // Fill to capacity, dropped fifth packet, then drain one group.
    drive(0, 4'd0, 0, 1'b1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive(4, 4'(k), 0, 1'b0);
      cyc();
    end
    check("t3_full_count", 64'(count), 64'd16);
    check("t3_full_ready", 64'(in_ready), 64'd0);
    drive(4, 4'd9, 0, 1'b0);
    cyc();
    check("t3_drop_count", 64'(count), 64'd16);
    drive(0, 4'd0, 4, 1'b0);
    cyc();
    check("t3_deq_count", 64'(count), 64'd12);
    check("t3_deq_ready", 64'(in_ready), 64'd1);

    // Move head/tail to 14, then enqueue across the wrap point.
    drive(0, 4'd0, 0, 1'b1);
    cyc();
    for (int k = 0; k < 4; k++) begin
      drive((k == 3) ? 2 : 4, 4'd1, 0, 1'b0);
      cyc();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 4'd0, (k == 3) ? 2 : 4, 1'b0);
      cyc();
    end
    check("t4_empty", 64'(count), 64'd0);
    drive(4, 4'd7, 0, 1'b0);
    saved = in_inst[0 +: 32];
    cyc();
    check("t4_lane0_W", 64'(out_inst[0 +: 32]), 64'(saved));
    check("t4_valid", 64'(out_valid), 64'hf);

    // Simultaneous enqueue of 4 and dequeue of 3 at count 5.
    drive(0, 4'd0, 0, 1'b1);
    cyc();
    drive(4, 4'd2, 0, 1'b0);
    saved = in_inst[96 +: 32];
    cyc();
    drive(1, 4'd2, 0, 1'b0);
    cyc();
    check("t5_count5", 64'(count), 64'd5);
    drive(4, 4'd5, 3, 1'b0);
    cyc();
    check("t5_count6", 64'(count), 64'd6);
    check("t5_lane0", 64'(out_inst[0 +: 32]), 64'(saved));

    // Flush beats a same-cycle enqueue and dequeue.
    drive(0, 4'd0, 0, 1'b1);
    cyc();
    drive(4, 4'd1, 0, 1'b0);
    cyc();
    drive(4, 4'd1, 0, 1'b0);
    cyc();
    check("t6_count8", 64'(count), 64'd8);
    drive(4, 4'd1, 2, 1'b1);
    cyc();
    check("t6_flush_count", 64'(count), 64'd0);
    check("t6_flush_valid", 64'(out_valid), 64'd0);

    // Randomized traffic with legal dequeue counts and occasional flush.
    for (int k = 0; k < 1500; k++) begin
      int sz;
      int mx;
      sz = q.size();
      mx = (sz < OW) ? sz : OW;
      drive(int'($urandom_range(0, 4)), 4'($urandom), int'($urandom_range(0, mx)),
            ($urandom_range(0, 39) == 0));
      cyc();
    end

    // Asynchronous reset in the middle of a cycle.
    drive(0, 4'd0, 0, 1'b0);
    cyc();
    #2 rst = 1'b0;
    #1;
    q.delete();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b1;
    cyc();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    drive(2, 4'd4, 0, 1'b0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
